// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Expected-output tables for common 2-input gates; bit i = Y for vector i
  localparam logic [3:0] TT_OR2  = 4'b1110;
  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_XOR2 = 4'b0110;

  // Settle counter width: enough to hold SETTLE, never narrower than 1 bit
  function automatic int unsigned cnt_width(input int unsigned settle);
    int unsigned w;
    w = $clog2(settle + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; expired is a registered flag meaning "count is 1".
module settle_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;
  logic [W-1:0] count_next;

  // Next count: load wins, otherwise decrement and stick at zero
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = value;
    end else if (count != '0) begin
      count_next = count - W'(1);
    end
  end

  // Count register with the expiry flag registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_next;
      expired <= (count_next == W'(1));
    end
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector into a gate, waits SETTLE cycles, checks Y
// against a truth table and records the error count and first failing vector.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned           N_IN   = 2,
  parameter int unsigned           SETTLE = 2,
  parameter logic [(2**N_IN)-1:0]  TRUTH  = TT_OR2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            y_in,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  localparam int unsigned NV = 2**N_IN;
  localparam int unsigned CW = cnt_width(SETTLE);
  // With no settle time a freshly driven vector is checked straight away
  localparam state_t      LOAD_ST = (SETTLE == 0) ? CHECK : WAIT;

  state_t          state;
  logic            sweep_go;
  logic            last_vec;
  logic            mismatch;
  logic            load;
  logic            expired;
  logic [N_IN:0]   err_next;

  // Decode helpers for the sweep control
  always_comb begin
    sweep_go = start && ((state == IDLE) || (state == DONE));
    last_vec = (stim == N_IN'(NV - 1));
    mismatch = (y_in != TRUTH[stim]);
    err_next = err_count + (N_IN + 1)'(mismatch);
    load     = sweep_go || ((state == CHECK) && !last_vec);
  end

  settle_timer #(
    .W (CW)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .value   (CW'(SETTLE)),
    .expired (expired)
  );

  // Sweep FSM with vector and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (sweep_go) begin
            stim      <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            state     <= LOAD_ST;
          end
        end
        WAIT: begin
          if (expired) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch && (err_count == '0)) begin
            fail_vec <= stim;
          end
          if (last_vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= DONE;
          end else begin
            stim  <= stim + N_IN'(1);
            state <= LOAD_ST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Self-checking bench: two checker instances (SETTLE=2 and SETTLE=0), each
// wrapped around a table-driven stand-in gate, compared against a sweep model.
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b;
  logic [3:0] tbl_a, tbl_b;

  logic [1:0] stim_a, stim_b, fail_a, fail_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [2:0] err_a, err_b;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gate_truth_checker #(.N_IN(2), .SETTLE(2), .TRUTH(TT_OR2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y_in(tbl_a[stim_a]),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_vec(fail_a)
  );

  gate_truth_checker #(.N_IN(2), .SETTLE(0), .TRUTH(TT_OR2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y_in(tbl_b[stim_b]),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_vec(fail_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: mismatches among the first vc vectors of a gate vs the OR table
  task automatic ref_results(input logic [3:0] gate, input int vc, output int err, output int fv);
    logic [3:0] tt;
    tt  = TT_OR2;
    err = 0;
    fv  = 0;
    for (int i = 0; i < vc; i++) begin
      if (gate[i] !== tt[i]) begin
        if (err == 0) fv = i;
        err++;
      end
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stim_a"}, 32'(stim_a), 32'd0);
    check({tag, "_busy_a"}, 32'(busy_a), 32'd0);
    check({tag, "_done_a"}, 32'(done_a), 32'd0);
    check({tag, "_pass_a"}, 32'(pass_a), 32'd0);
    check({tag, "_err_a"},  32'(err_a),  32'd0);
    check({tag, "_fail_a"}, 32'(fail_a), 32'd0);
    check({tag, "_done_b"}, 32'(done_b), 32'd0);
    check({tag, "_err_b"},  32'(err_b),  32'd0);
  endtask

  // One full sweep with a cycle-by-cycle comparison; ign>0 pulses start mid-sweep
  task automatic run_sweep(input bit sel, input logic [3:0] gate, input int settle, input int ign);
    int n, vc, e_err, e_fv, e_stim;
    logic [1:0] s, f;
    logic       b, d, p;
    logic [2:0] e;
    n = 4 * (settle + 1);
    if (sel) tbl_b = gate; else tbl_a = gate;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1 set_start(sel, 1'b0);
    for (int k = 1; k <= n + 3; k++) begin
      @(posedge clk);
      #1;
      set_start(sel, (k == ign) ? 1'b1 : 1'b0);
      if (sel) begin s = stim_b; b = busy_b; d = done_b; p = pass_b; e = err_b; f = fail_b; end
      else     begin s = stim_a; b = busy_a; d = done_a; p = pass_a; e = err_a; f = fail_a; end
      vc = k / (settle + 1);
      if (vc > 4) vc = 4;
      e_stim = (vc > 3) ? 3 : vc;
      ref_results(gate, vc, e_err, e_fv);
      check($sformatf("stim_s%0d_k%0d", settle, k), 32'(s), 32'(e_stim));
      check($sformatf("busy_s%0d_k%0d", settle, k), 32'(b), 32'(k < n));
      check($sformatf("done_s%0d_k%0d", settle, k), 32'(d), 32'(k >= n));
      check($sformatf("pass_s%0d_k%0d", settle, k), 32'(p), 32'((k >= n) && (e_err == 0)));
      check($sformatf("err_s%0d_k%0d",  settle, k), 32'(e), 32'(e_err));
      check($sformatf("fvec_s%0d_k%0d", settle, k), 32'(f), 32'(e_fv));
    end
  endtask

  initial begin
    logic [31:0] r;
    checks   = 0;
    failures = 0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    tbl_a    = TT_OR2;
    tbl_b    = TT_OR2;
    rst_n    = 1'b1;

    // Reset, then idle with start low
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_all_zero("idle");

    // Correct OR gate, default settle
    run_sweep(1'b0, TT_OR2, 2, -1);
    // Faulty AND gate: mismatches at vectors 1 and 2
    run_sweep(1'b0, TT_AND2, 2, -1);
    check("and_err_final", 32'(err_a), 32'd2);
    check("and_fvec_final", 32'(fail_a), 32'd1);
    // Stray start at cycle 5 is ignored; the rerun from DONE clears results
    run_sweep(1'b0, TT_OR2, 2, 5);
    // SETTLE=0 instance with OR and XOR gates
    run_sweep(1'b1, TT_OR2, 0, -1);
    run_sweep(1'b1, TT_XOR2, 0, -1);

    // Randomized gate tables on both instances
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      run_sweep(1'b0, r[3:0], 2, -1);
      run_sweep(1'b1, r[7:4], 0, (i == 2) ? 2 : -1);
    end

    // Reset during vector 2's wait phase: outputs clear asynchronously
    tbl_a = TT_OR2;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_stim", 32'(stim_a), 32'd2);
    check("mid_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_sweep(1'b0, TT_OR2, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
